// File: rtl/led_pulse_stretcher_pkg.sv
// Shared types and constants for the LED pulse stretcher: phase encoding,
// board-clock conversion and timer sizing helpers.
package led_pulse_stretcher_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam int MHZ = 50;

    function automatic int ms_to_cyc(input int ms);
        return ms * MHZ * 1000;
    endfunction

    // Down-counter width for the longer of the two phases, never below 1 bit.
    function automatic int tmr_width(input int on_cyc, input int off_cyc);
        int m;
        m = (on_cyc > off_cyc) ? on_cyc : off_cyc;
        return ($clog2(m) < 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/led_pulse_stretcher_phase_timer.sv
// Loadable down-counter that parks at zero; sequences the ON and GAP phases.
module led_pulse_stretcher_phase_timer #(
    parameter int W = 2
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/led_pulse_stretcher.sv
// Turns single-cycle event strobes into fixed-length LED pulses separated by a
// fixed gap, queueing events that arrive while a pulse is in progress.
module led_pulse_stretcher
    import led_pulse_stretcher_pkg::*;
#(
    parameter int ON_CYC   = ms_to_cyc(100),
    parameter int OFF_CYC  = ms_to_cyc(100),
    parameter int MAX_PEND = 7,
    localparam int PEND_W  = $clog2(MAX_PEND + 1)
) (
    input  logic              src_clk,
    input  logic              rst,
    input  logic              pulse_in,
    output logic              led_out,
    output logic              busy,
    output logic [PEND_W-1:0] pend_cnt,
    output logic              overflow
);

    localparam int TMR_W = tmr_width(ON_CYC, OFF_CYC);
    localparam logic [TMR_W-1:0]  ON_LOAD  = TMR_W'(ON_CYC - 1);
    localparam logic [TMR_W-1:0]  OFF_LOAD = TMR_W'(OFF_CYC - 1);
    localparam logic [PEND_W:0]   MAX_P    = (PEND_W + 1)'(MAX_PEND);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_led;
    logic                w_led_nxt;
    logic [PEND_W-1:0]   r_pend;
    logic [PEND_W-1:0]   w_pend_nxt;
    logic [PEND_W:0]     w_pend_sum;
    logic                r_ovf;
    logic                w_drop;
    logic                w_start;
    logic                w_zero;
    logic                w_load;
    logic [TMR_W-1:0]    w_load_val;

    led_pulse_stretcher_phase_timer #(
        .W (TMR_W)
    ) u_phase_timer (
        .i_clk      (src_clk),
        .i_rst      (rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_zero     (w_zero)
    );

    // The last GAP cycle behaves like IDLE so queued events chain without a gap cycle.
    always_comb begin
        w_start = ((r_state == ST_IDLE) || ((r_state == ST_GAP) && w_zero))
                  && (pulse_in || (r_pend != '0));
    end

    always_comb begin
        w_state_nxt = r_state;
        w_led_nxt   = r_led;
        w_load      = 1'b0;
        w_load_val  = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt = ST_ON;
                    w_led_nxt   = 1'b1;
                    w_load      = 1'b1;
                    w_load_val  = ON_LOAD;
                end
            end
            ST_ON: begin
                if (w_zero) begin
                    w_state_nxt = ST_GAP;
                    w_led_nxt   = 1'b0;
                    w_load      = 1'b1;
                    w_load_val  = OFF_LOAD;
                end
            end
            ST_GAP: begin
                if (w_start) begin
                    w_state_nxt = ST_ON;
                    w_led_nxt   = 1'b1;
                    w_load      = 1'b1;
                    w_load_val  = ON_LOAD;
                end else if (w_zero) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_led_nxt   = 1'b0;
            end
        endcase
    end

    // One extra bit catches the only overflow case: pulse with no start at MAX_PEND.
    always_comb begin
        w_pend_sum = {1'b0, r_pend} + {{PEND_W{1'b0}}, pulse_in}
                     - {{PEND_W{1'b0}}, w_start};
        w_drop     = (w_pend_sum > MAX_P);
        w_pend_nxt = w_drop ? MAX_P[PEND_W-1:0] : w_pend_sum[PEND_W-1:0];
    end

    always_ff @(posedge src_clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_led   <= 1'b0;
            r_pend  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_led   <= w_led_nxt;
            r_pend  <= w_pend_nxt;
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign led_out  = r_led;
    assign busy     = (r_state != ST_IDLE);
    assign pend_cnt = r_pend;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// Scenario-table and hand-sequence bench for led_pulse_stretcher (ON=4, OFF=3, MAX_PEND=3).
module tb_led_pulse_stretcher;

    localparam int NCYC = 40;
    localparam int NSCN = 6;

    logic       src_clk = 1'b0;
    logic       rst = 1'b1;
    logic       pulse_in = 1'b0;
    logic       led_out;
    logic       busy;
    logic [1:0] pend_cnt;
    logic       overflow;

    led_pulse_stretcher #(
        .ON_CYC   (4),
        .OFF_CYC  (3),
        .MAX_PEND (3)
    ) dut (
        .src_clk  (src_clk),
        .rst      (rst),
        .pulse_in (pulse_in),
        .led_out  (led_out),
        .busy     (busy),
        .pend_cnt (pend_cnt),
        .overflow (overflow)
    );

    always #5 src_clk = ~src_clk;

    typedef struct packed {
        logic [NCYC-1:0] pulse;
        logic [NCYC-1:0] rstm;
        logic [NCYC-1:0] led;
        logic [NCYC-1:0] busy;
        logic [5:0]      ovf_from;
        logic [2:0]      np;
        logic [5:0][5:0] p_cyc;
        logic [5:0][1:0] p_val;
    } vec_t;

    typedef struct packed {
        logic       led;
        logic       busy;
        logic [1:0] pend;
        logic       ovf;
    } exp_t;

    vec_t tbl [NSCN];
    exp_t sbq [$];
    int   n_chk = 0;
    int   n_fail = 0;

    function automatic logic [NCYC-1:0] rng(input int lo, input int hi);
        logic [NCYC-1:0] r;
        r = '0;
        for (int i = lo; i <= hi; i++) r[i] = 1'b1;
        return r;
    endfunction

    function automatic exp_t exp_at(input int s, input int c);
        exp_t e;
        e.led  = tbl[s].led[c];
        e.busy = tbl[s].busy[c];
        e.pend = 2'd0;
        for (int i = 0; i < int'(tbl[s].np); i++)
            if (c >= int'(tbl[s].p_cyc[i])) e.pend = tbl[s].p_val[i];
        e.ovf  = (c >= int'(tbl[s].ovf_from));
        return e;
    endfunction

    task automatic add_pend(input int s, input int cyc, input int val);
        tbl[s].p_cyc[tbl[s].np] = 6'(cyc);
        tbl[s].p_val[tbl[s].np] = 2'(val);
        tbl[s].np = tbl[s].np + 3'd1;
    endtask

    task automatic chk(input string nm, input int s, input int c,
                       input logic [7:0] act, input logic [7:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s scen%0d cyc%0d: got %0d, expected %0d", nm, s, c, act, req);
        end
    endtask

    task automatic do_reset();
        @(negedge src_clk);
        rst = 1'b1;
        pulse_in = 1'b0;
        sbq.delete();
        repeat (2) @(posedge src_clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e, g;

        for (int s = 0; s < NSCN; s++) begin
            tbl[s] = '0;
            tbl[s].ovf_from = 6'd63;
        end
        // single event from IDLE
        tbl[0].pulse = rng(10, 10);
        tbl[0].led   = rng(11, 14);
        tbl[0].busy  = rng(11, 17);
        // three back-to-back events replayed at the ON+OFF period
        tbl[1].pulse = rng(10, 12);
        tbl[1].led   = rng(11, 14) | rng(18, 21) | rng(25, 28);
        tbl[1].busy  = rng(11, 31);
        add_pend(1, 12, 1); add_pend(1, 13, 2); add_pend(1, 18, 1); add_pend(1, 25, 0);
        // five events: queue saturates, fifth dropped
        tbl[2].pulse = rng(10, 14);
        tbl[2].led   = rng(11, 14) | rng(18, 21) | rng(25, 28) | rng(32, 35);
        tbl[2].busy  = rng(11, 38);
        tbl[2].ovf_from = 6'd15;
        add_pend(2, 12, 1); add_pend(2, 13, 2); add_pend(2, 14, 3);
        add_pend(2, 18, 2); add_pend(2, 25, 1); add_pend(2, 32, 0);
        // event in the last GAP cycle
        tbl[3].pulse = rng(10, 10) | rng(17, 17);
        tbl[3].led   = rng(11, 14) | rng(18, 21);
        tbl[3].busy  = rng(11, 24);
        // reset mid-ON, then a fresh event
        tbl[4].pulse = rng(10, 10) | rng(20, 20);
        tbl[4].rstm  = rng(12, 12);
        tbl[4].led   = rng(11, 12) | rng(21, 24);
        tbl[4].busy  = rng(11, 12) | rng(21, 27);
        // event coincident with reset is ignored
        tbl[5].pulse = rng(10, 10);
        tbl[5].rstm  = rng(10, 10);

        for (int s = 0; s < NSCN; s++) begin
            do_reset();
            sbq.push_back(exp_at(s, 0));
            for (int c = 0; c < NCYC; c++) begin
                @(negedge src_clk);
                if (sbq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL scoreboard scen%0d cyc%0d: queue empty, expected an entry", s, c);
                end else begin
                    e = sbq.pop_front();
                    g = '{led: led_out, busy: busy, pend: pend_cnt, ovf: overflow};
                    chk("led_out",  s, c, 8'(g.led),  8'(e.led));
                    chk("busy",     s, c, 8'(g.busy), 8'(e.busy));
                    chk("pend_cnt", s, c, 8'(g.pend), 8'(e.pend));
                    chk("overflow", s, c, 8'(g.ovf),  8'(e.ovf));
                end
                rst      = tbl[s].rstm[c];
                pulse_in = tbl[s].pulse[c];
                if (c + 1 < NCYC) sbq.push_back(exp_at(s, c + 1));
            end
        end

        // Full queue: pulse coinciding with a start is kept, a pulse without one is dropped;
        // overflow then stays set until reset.
        do_reset();
        for (int c = 0; c <= 40; c++) begin
            @(negedge src_clk);
            if (c == 14) begin
                chk("h_pend_full", 6, c, 8'(pend_cnt), 8'd3);
                chk("h_ovf_full",  6, c, 8'(overflow), 8'd0);
            end
            if (c == 18) begin
                chk("h_pend_start_at_max", 6, c, 8'(pend_cnt), 8'd3);
                chk("h_ovf_start_at_max",  6, c, 8'(overflow), 8'd0);
                chk("h_led_chain",         6, c, 8'(led_out),  8'd1);
                chk("h_busy_chain",        6, c, 8'(busy),     8'd1);
            end
            if (c == 19) begin
                chk("h_ovf_drop",  6, c, 8'(overflow), 8'd1);
                chk("h_pend_drop", 6, c, 8'(pend_cnt), 8'd3);
            end
            if (c == 25) begin
                chk("h_pend_replay", 6, c, 8'(pend_cnt), 8'd2);
                chk("h_led_replay",  6, c, 8'(led_out),  8'd1);
            end
            if (c == 34) chk("h_ovf_sticky", 6, c, 8'(overflow), 8'd1);
            if (c == 36) begin
                chk("h_ovf_rst",  6, c, 8'(overflow), 8'd0);
                chk("h_pend_rst", 6, c, 8'(pend_cnt), 8'd0);
                chk("h_led_rst",  6, c, 8'(led_out),  8'd0);
                chk("h_busy_rst", 6, c, 8'(busy),     8'd0);
            end
            pulse_in = ((c >= 10) && (c <= 13)) || (c == 17) || (c == 18);
            rst      = (c == 35);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
